alu_wrapper: RTL and testbench
==============================

# alu_wrapper

Board-level test harness around the 16-bit ALU. A single 10-bit input bus is captured into three internal registers (opcode, source operand, destination operand) under active-low load strobes. The ALU result and 5-bit status flags are presented combinationally from those registers. It sits between board switches/pushbuttons and the datapath ALU for bring-up and lab demonstration.

## Interface
- No parameters.
- clk  input  1  system clock; all registers update on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clears all registers.
- data_input  input  10  shared load bus for opcode and operands.
- ld_op_code  input  1  active-low load strobe for the opcode register (captures data_input[3:0]).
- ld_src  input  1  active-low load strobe for the source register (captures sign-extended data_input).
- ld_dest  input  1  active-low load strobe for the destination register (captures sign-extended data_input).
- Flags  output  5  {N, Z, F, L, C} = Flags[4:0]; N is bit 4 and C is bit 0.
- Out  output  16  ALU result.

## Operation
- Registers:
  - op[3:0] loads data_input[3:0] on each rising edge where ld_op_code==0.
  - src[15:0] loads {{6{data_input[9]}}, data_input} on each rising edge where ld_src==0.
  - dest[15:0] loads the same sign-extended value on each rising edge where ld_dest==0.
- Strobes are level-sensitive. A strobe held low reloads its register on every edge.
- Several strobes low on the same edge load the same bus value into each selected register.
- Opcodes (result computed from dest and src):
  - 0x0 NOP: Out=0, Flags=0.
  - 0x1 ADD: dest+src.
  - 0x2 AND: dest&src.
  - 0x3 OR: dest|src.
  - 0x4 XOR: dest^src.
  - 0x5 SUB: dest−src.
  - 0x6 CMP: Out=dest; flags reflect dest−src.
  - 0x7 NOT: ~src.
  - 0x8 LSH: dest<<1.
  - 0x9 RSH: dest>>1 (logical).
  - 0xA ARSH: dest>>>1.
  - 0xB MOV: src.
  - 0xC–0xF: treated as NOP.
- Flags:
  - C: carry-out for ADD; borrow (dest<src unsigned) for SUB/CMP; shifted-out bit for LSH/RSH/ARSH (dest[15] for LSH, dest[0] for right shifts); 0 otherwise.
  - L: dest<src unsigned, for SUB/CMP only; 0 otherwise.
  - F: two's-complement overflow for ADD/SUB/CMP; 0 otherwise.
  - Z: Out==0 for every non-NOP op; for CMP, Z = (dest==src).
  - N: Out[15] for every non-NOP op; for CMP, N = dest<src signed.
- All arithmetic is 16-bit modulo 2^16.

## Timing
- Reset: asserting rst_n low immediately clears op, src and dest to 0. Out=0x0000 and Flags=5'b00000 with no clock needed. Reset mid-sequence discards all loaded values.
- Load latency is one edge: a register reflects data_input after the rising edge that samples its strobe low.
- Out and Flags are purely combinational from the registers. They are valid in the same cycle as the last register update, with no extra pipeline stage.
- There is no handshake and no busy state. The result tracks register contents continuously.

## Test plan
- OR:
  - Stimulus: op=0x3, src bus 10'h155 (0x0155), dest bus 10'h2AA (0xFEAA), strobes pulsed low one cycle each.
  - Required: Out=0xFFFF, Flags=5'b10000.
- SUB borrow:
  - Stimulus: op=0x5, dest=0x0005, src=0x0007.
  - Required: Out=0xFFFE, Flags=5'b10011 (N, L, C).
- ADD carry:
  - Stimulus: op=0x1, dest=src=bus 10'h200 (0xFE00).
  - Required: Out=0xFC00, Flags=5'b10001.
- CMP equal:
  - Stimulus: op=0x6, dest=src=0x0123.
  - Required: Out=0x0123, Flags=5'b01000.
- Held strobe:
  - Stimulus: ld_op_code kept low while the bus changes from 0x003 to 0x155.
  - Required: op becomes 0x5 on the next edge and Out switches to SUB.
- Async reset:
  - Stimulus: after any of the loads above, drive rst_n=0 between clock edges.
  - Required: Out=0x0000 and Flags=0 immediately; they stay 0 after rst_n returns high until new loads occur.

Source files
------------

// File: rtl/alu_wrapper.sv
// rtl/alu_wrapper.sv - bring-up harness: bus-loaded opcode/operand registers feeding a 16-bit ALU
module alu_wrapper (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  data_input,
   input  logic        ld_op_code,
   input  logic        ld_src,
   input  logic        ld_dest,
   output logic [4:0]  Flags,
   output logic [15:0] Out
);

   logic [3:0]  r_op;
   logic [15:0] r_src;
   logic [15:0] r_dest;

   logic [15:0] w_ext;
   logic [16:0] w_sum;
   logic [16:0] w_diff;
   logic        w_add_ovf;
   logic        w_sub_ovf;
   logic        w_borrow;

   assign w_ext = {{6{data_input[9]}}, data_input};

   // Strobes are level-sensitive: a strobe held low reloads on every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op   <= 4'h0;
         r_src  <= 16'h0000;
         r_dest <= 16'h0000;
      end else begin
         if (!ld_op_code) r_op   <= data_input[3:0];
         if (!ld_src)     r_src  <= w_ext;
         if (!ld_dest)    r_dest <= w_ext;
      end
   end

   assign w_sum     = {1'b0, r_dest} + {1'b0, r_src};
   assign w_diff    = {1'b0, r_dest} - {1'b0, r_src};
   assign w_borrow  = w_diff[16];
   assign w_add_ovf = (r_dest[15] == r_src[15]) && (w_sum[15]  != r_dest[15]);
   assign w_sub_ovf = (r_dest[15] != r_src[15]) && (w_diff[15] != r_dest[15]);

   logic [15:0] w_out;
   logic        w_n, w_z, w_f, w_l, w_c;

   always_comb begin
      w_out = 16'h0000;
      w_c   = 1'b0;
      w_l   = 1'b0;
      w_f   = 1'b0;
      case (r_op)
         4'h1: begin w_out = w_sum[15:0]; w_c = w_sum[16]; w_f = w_add_ovf; end
         4'h2: w_out = r_dest & r_src;
         4'h3: w_out = r_dest | r_src;
         4'h4: w_out = r_dest ^ r_src;
         4'h5: begin w_out = w_diff[15:0]; w_c = w_borrow; w_l = w_borrow; w_f = w_sub_ovf; end
         4'h6: begin w_out = r_dest;       w_c = w_borrow; w_l = w_borrow; w_f = w_sub_ovf; end
         4'h7: w_out = ~r_src;
         4'h8: begin w_out = {r_dest[14:0], 1'b0};       w_c = r_dest[15]; end
         4'h9: begin w_out = {1'b0, r_dest[15:1]};       w_c = r_dest[0];  end
         4'hA: begin w_out = {r_dest[15], r_dest[15:1]}; w_c = r_dest[0];  end
         4'hB: w_out = r_src;
         default: w_out = 16'h0000;
      endcase

      w_n = w_out[15];
      w_z = (w_out == 16'h0000);
      // CMP reports the relation of dest to src rather than properties of Out.
      if (r_op == 4'h6) begin
         w_z = (w_diff[15:0] == 16'h0000);
         w_n = w_diff[15] ^ w_sub_ovf;
      end else if (r_op == 4'h0 || r_op > 4'hB) begin
         w_z = 1'b0;
         w_n = 1'b0;
      end
   end

   assign Out   = w_out;
   assign Flags = {w_n, w_z, w_f, w_l, w_c};

endmodule

// File: tb/tb_alu_wrapper.sv
// tb/tb_alu_wrapper.sv - randomized and directed self-checking bench for alu_wrapper
module tb_alu_wrapper;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [9:0]  data_input = '0;
   logic        ld_op_code = 1'b1;
   logic        ld_src = 1'b1;
   logic        ld_dest = 1'b1;
   logic [4:0]  Flags;
   logic [15:0] Out;

   int checks = 0;
   int failures = 0;
   int m_op = 0, m_src = 0, m_dest = 0;

   alu_wrapper dut (
      .clk(clk), .rst_n(rst_n), .data_input(data_input),
      .ld_op_code(ld_op_code), .ld_src(ld_src), .ld_dest(ld_dest),
      .Flags(Flags), .Out(Out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int sext(input int bus);
      return (bus >= 512) ? bus + 65536 - 1024 : bus;
   endfunction

   function automatic int to_signed(input int v);
      return (v >= 32768) ? v - 65536 : v;
   endfunction

   // Returns {flags[4:0], out[15:0]} from the arithmetic definition of each opcode.
   function automatic logic [20:0] model(input int op, input int d, input int s);
      int r, c, l, f, n, z, sd, ss, wide;
      logic [15:0] o;
      sd = to_signed(d); ss = to_signed(s);
      r = 0; c = 0; l = 0; f = 0;
      case (op)
         1: begin r = d + s; c = (r > 65535); wide = sd + ss; f = (wide > 32767 || wide < -32768); end
         2: r = d & s;
         3: r = d | s;
         4: r = d ^ s;
         5, 6: begin r = d - s; c = (d < s); l = c; wide = sd - ss; f = (wide > 32767 || wide < -32768); end
         7: r = 65535 - s;
         8: begin r = d * 2; c = (d >= 32768); end
         9: begin r = d / 2; c = d % 2; end
         10: begin r = d / 2 + ((d >= 32768) ? 32768 : 0); c = d % 2; end
         11: r = s;
         default: r = 0;
      endcase
      r = r & 65535;
      o = r[15:0];
      n = (r >= 32768);
      z = (r == 0);
      if (op == 6) begin
         o = d[15:0];
         z = (d == s);
         n = (sd < ss);
      end
      if (op == 0 || op > 11) begin
         o = 16'h0; c = 0; l = 0; f = 0; n = 0; z = 0;
      end
      return {n[0], z[0], f[0], l[0], c[0], o};
   endfunction

   task automatic check_model(input string tag);
      logic [20:0] e;
      e = model(m_op, m_dest, m_src);
      check({tag, ".out"},   {16'h0, Out},   {16'h0, e[15:0]});
      check({tag, ".flags"}, {27'h0, Flags}, {27'h0, e[20:16]});
   endtask

   // Drive one cycle of bus/strobes from just after a falling edge; model captures on the rising edge.
   task automatic step(input int bus, input logic lo, input logic ls, input logic ld);
      data_input = bus[9:0]; ld_op_code = lo; ld_src = ls; ld_dest = ld;
      @(posedge clk);
      if (!lo) m_op = bus & 15;
      if (!ls) m_src = sext(bus);
      if (!ld) m_dest = sext(bus);
      @(negedge clk);
      ld_op_code = 1'b1; ld_src = 1'b1; ld_dest = 1'b1;
   endtask

   task automatic load3(input int op, input int dbus, input int sbus);
      step(op, 1'b0, 1'b1, 1'b1);
      step(sbus, 1'b1, 1'b0, 1'b1);
      step(dbus, 1'b1, 1'b1, 1'b0);
   endtask

   initial begin
      #2;
      check("reset.out", {16'h0, Out}, 32'h0);
      check("reset.flags", {27'h0, Flags}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      load3(3, 10'h2AA, 10'h155);
      check("or.out", {16'h0, Out}, 32'hFFFF);
      check("or.flags", {27'h0, Flags}, 32'h10);

      load3(5, 5, 7);
      check("sub.out", {16'h0, Out}, 32'hFFFE);
      check("sub.flags", {27'h0, Flags}, 32'h13);

      load3(1, 10'h200, 10'h200);
      check("add.out", {16'h0, Out}, 32'hFC00);
      check("add.flags", {27'h0, Flags}, 32'h11);

      load3(6, 10'h123, 10'h123);
      check("cmp.out", {16'h0, Out}, 32'h0123);
      check("cmp.flags", {27'h0, Flags}, 32'h08);

      // Held opcode strobe: OR then SUB on consecutive edges, with dest=0x0009, src=0x0003.
      load3(3, 9, 3);
      data_input = 10'h003; ld_op_code = 1'b0;
      @(posedge clk); m_op = 3;
      @(negedge clk);
      check("held.or", {16'h0, Out}, 32'h000B);
      data_input = 10'h155;
      @(posedge clk); m_op = 5;
      @(negedge clk);
      check("held.sub", {16'h0, Out}, 32'h0006);
      check_model("held.model");
      ld_op_code = 1'b1;

      // Several strobes on one edge: dest=src=op bus value 0x001 gives ADD 1+1.
      step(1, 1'b0, 1'b0, 1'b0);
      check("multi.out", {16'h0, Out}, 32'h0002);

      #2 rst_n = 1'b0;
      #1;
      check("areset.out", {16'h0, Out}, 32'h0);
      check("areset.flags", {27'h0, Flags}, 32'h0);
      m_op = 0; m_src = 0; m_dest = 0;
      @(negedge clk);
      rst_n = 1'b1;
      step(10'h3FF, 1'b1, 1'b1, 1'b1);
      check("postreset.out", {16'h0, Out}, 32'h0);
      check("postreset.flags", {27'h0, Flags}, 32'h0);

      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 1023), ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) != 0),
              ($urandom_range(0, 1) != 0));
         check_model("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
